// File: rtl/les_sched.sv
// rtl/les_sched.sv - two-requester round-robin scheduler in front of a shared cipher core
// Optional WAIT-state timeout: define LES_SCHED_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module les_sched #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        core_start,
    output logic [31:0] core_plaintext,
    input  logic        core_busy,
    input  logic [31:0] core_cipher,
    output logic        core_clr
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q, id_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        grant0, grant1;

`ifdef LES_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
    logic             tclr_q, tclr_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        data_d       = data_q;
        rsp_data_d   = rsp_data_q;
        grant0       = 1'b0;
        grant1       = 1'b0;
`ifdef LES_SCHED_TIMEOUT_EN
        cnt_d        = cnt_q;
        rsp_err_d    = rsp_err_q;
        tclr_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // Under contention requester 0 wins only if requester 1 had the last grant.
                if (req0 && (!req1 || last_grant_q)) begin
                    grant0 = 1'b1;
                end else if (req1) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    id_d         = grant1;
                    last_grant_d = grant1;
                    data_d       = grant1 ? data1 : data0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef LES_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (!core_busy) begin
                    rsp_data_d = core_cipher;
`ifdef LES_SCHED_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
`endif
                    state_d    = S_RESP;
                end
`ifdef LES_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    tclr_d     = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            data_q       <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            data_q       <= data_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

`ifdef LES_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
            tclr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
            tclr_q    <= tclr_d;
        end
    end

    assign rsp_err  = rsp_err_q;
    assign core_clr = clr | tclr_q;
`else
    assign rsp_err  = 1'b0;
    assign core_clr = clr;
`endif

    // Acks are combinational from the IDLE grant; reset must silence them immediately.
    assign ack0           = grant0 & ~clr;
    assign ack1           = grant1 & ~clr;
    assign core_start     = (state_q == S_ISSUE);
    assign rsp_valid      = (state_q == S_RESP);
    assign rsp_id         = id_q;
    assign rsp_data       = rsp_data_q;
    assign core_plaintext = data_q;

endmodule
